// File: rtl/cpu_pkg.sv
// Shared RV32I types and constants for the pipeline: opcodes, control bundle and ALU op encoding.
package cpu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src_imm;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    branch;
    logic    jump;
    logic    jalr;
    logic    lui;
    logic    auipc;
  } ctrl_t;

  // funct7[5] selects SUB only for register-register ops; SRA/SRL for both forms.
  function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic f7b5,
                                         input logic is_reg);
    alu_op_t op;
    op = AluAdd;
    case (f3)
      3'b000:  op = (is_reg && f7b5) ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = f7b5 ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF/EX/WB-facing signal bundle of the decode stage.
interface id_stage_if;
  import cpu_pkg::*;

  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            is_flush;
  logic            ex_mem_read;
  logic [4:0]      ex_rd;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            is_stall;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [2:0]      funct3;
  logic            funct7_b5;
  ctrl_t           ctrl;
  logic            is_illegal;

  modport master (
    output if_valid, if_pc, if_instr, is_flush, ex_mem_read, ex_rd, wb_we, wb_rd, wb_data,
    input  is_stall, id_valid, id_pc, rs1, rs2, rd, rs1_data, rs2_data, imm, funct3,
           funct7_b5, ctrl, is_illegal
  );

  modport slave (
    input  if_valid, if_pc, if_instr, is_flush, ex_mem_read, ex_rd, wb_we, wb_rd, wb_data,
    output is_stall, id_valid, id_pc, rs1, rs2, rd, rs1_data, rs2_data, imm, funct3,
           funct7_b5, ctrl, is_illegal
  );
endinterface

// File: rtl/reg_file.sv
// 32x32 architectural register file: one write port, two write-through read ports, x0 hardwired.
module reg_file
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign wr_en = we && (waddr != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else if (wr_en) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Bypass the WB write so decode sees it without an extra cycle.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != 5'd0) rdata1 = (wr_en && waddr == raddr1) ? wdata : regs_q[raddr1];
    if (raddr2 != 5'd0) rdata2 = (wr_en && waddr == raddr2) ? wdata : regs_q[raddr2];
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, instruction decode, load-use hazard detection and
// register-file read.
module id_stage
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  id_stage_if.slave  bus
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;

  logic [6:0]      opcode;
  ctrl_t           dec;
  logic            legal;
  logic [XLEN-1:0] imm_dec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (bus.is_flush) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end else if (!bus.is_stall) begin
      valid_d = bus.if_valid;
      pc_d    = bus.if_pc;
      instr_d = bus.if_instr;
    end
  end

  assign opcode        = instr_q[6:0];
  assign bus.rs1       = instr_q[19:15];
  assign bus.rs2       = instr_q[24:20];
  assign bus.rd        = instr_q[11:7];
  assign bus.funct3    = instr_q[14:12];
  assign bus.funct7_b5 = instr_q[30];
  assign bus.id_pc     = pc_q;
  assign bus.imm       = imm_dec;

  always_comb begin
    dec        = '0;
    dec.alu_op = AluAdd;
    legal      = 1'b1;
    imm_dec    = '0;
    case (opcode)
      OP: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = alu_decode(instr_q[14:12], instr_q[30], 1'b1);
      end
      OP_IMM: begin
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        dec.alu_op      = alu_decode(instr_q[14:12], instr_q[30], 1'b0);
        imm_dec         = {{20{instr_q[31]}}, instr_q[31:20]};
      end
      LOAD: begin
        dec.reg_write   = 1'b1;
        dec.mem_read    = 1'b1;
        dec.alu_src_imm = 1'b1;
        imm_dec         = {{20{instr_q[31]}}, instr_q[31:20]};
      end
      STORE: begin
        dec.mem_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        imm_dec         = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      end
      BRANCH: begin
        dec.branch = 1'b1;
        dec.alu_op = AluSub;
        imm_dec    = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                      instr_q[11:8], 1'b0};
      end
      JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        imm_dec       = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                         instr_q[30:21], 1'b0};
      end
      JALR: begin
        dec.jump        = 1'b1;
        dec.jalr        = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        imm_dec         = {{20{instr_q[31]}}, instr_q[31:20]};
      end
      LUI: begin
        dec.lui         = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        imm_dec         = {instr_q[31:12], 12'b0};
      end
      AUIPC: begin
        dec.auipc       = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
        imm_dec         = {instr_q[31:12], 12'b0};
      end
      MISC_MEM, SYSTEM: ; // legal, but no datapath side effects at this stage
      default: legal = 1'b0;
    endcase
  end

  // rs2 is compared even for formats without it; a spurious stall only costs a cycle.
  assign bus.is_stall = valid_q && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                        ((bus.ex_rd == bus.rs1) || (bus.ex_rd == bus.rs2));

  assign bus.id_valid   = valid_q && !bus.is_stall;
  assign bus.is_illegal = bus.id_valid && !legal;
  assign bus.ctrl       = (bus.id_valid && legal) ? dec : '0;

  reg_file u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .we     (bus.wb_we),
    .waddr  (bus.wb_rd),
    .wdata  (bus.wb_data),
    .raddr1 (bus.rs1),
    .raddr2 (bus.rs2),
    .rdata1 (bus.rs1_data),
    .rdata2 (bus.rs2_data)
  );

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, write-through, load-use stall, flush and reset.
module tb_id_stage;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  int   n_fail;

  id_stage_if bus ();

  id_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input ctrl_t exp);
    n_total++;
    assert (bus.ctrl === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed ctrl %h expected ctrl %h", tag, bus.ctrl, exp);
    end
  endtask

  // bits = {alu_src_imm, mem_read, mem_write, reg_write, branch, jump, jalr, lui, auipc}
  function automatic ctrl_t mk(input alu_op_t op, input logic [8:0] bits);
    ctrl_t c;
    c.alu_op      = op;
    c.alu_src_imm = bits[8];
    c.mem_read    = bits[7];
    c.mem_write   = bits[6];
    c.reg_write   = bits[5];
    c.branch      = bits[4];
    c.jump        = bits[3];
    c.jalr        = bits[2];
    c.lui         = bits[1];
    c.auipc       = bits[0];
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
    bus.if_instr = instr;
    tick();
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    reset           = 1'b0;
    bus.if_valid    = 1'b0;
    bus.if_pc       = '0;
    bus.if_instr    = '0;
    bus.is_flush    = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rd       = '0;
    bus.wb_we       = 1'b0;
    bus.wb_rd       = '0;
    bus.wb_data     = '0;

    #3;
    chk("rst_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_pc", bus.id_pc, 32'd0);
    chk("rst_imm", bus.imm, 32'd0);
    chk_ctrl("rst_ctrl", '0);
    chk("rst_illegal", 32'(bus.is_illegal), 32'd0);

    @(negedge clk);
    reset = 1'b1;

    // addi x1, x0, 5
    fetch(32'h100, 32'h0050_0093);
    chk("addi_valid", 32'(bus.id_valid), 32'd1);
    chk("addi_pc", bus.id_pc, 32'h100);
    chk("addi_rd", 32'(bus.rd), 32'd1);
    chk("addi_imm", bus.imm, 32'd5);
    chk_ctrl("addi_ctrl", mk(AluAdd, 9'b1_0_0_1_0_0_0_0_0));

    // add x4, x3, x0 with a same-cycle WB write of x3
    fetch(32'h104, 32'h0001_8233);
    bus.wb_we   = 1'b1;
    bus.wb_rd   = 5'd3;
    bus.wb_data = 32'hDEAD_BEEF;
    #1;
    chk("wt_rs1", bus.rs1_data, 32'hDEAD_BEEF);
    chk_ctrl("add_ctrl", mk(AluAdd, 9'b0_0_0_1_0_0_0_0_0));
    tick();
    bus.wb_we = 1'b0;
    #1;
    chk("stored_rs1", bus.rs1_data, 32'hDEAD_BEEF);
    bus.wb_we   = 1'b1;
    bus.wb_rd   = 5'd0;
    bus.wb_data = 32'hFFFF_FFFF;
    #1;
    chk("x0_wt", bus.rs2_data, 32'd0);
    tick();
    bus.wb_we = 1'b0;
    #1;
    chk("x0_after", bus.rs2_data, 32'd0);

    // add x5, x2, x1 behind a load to x2
    fetch(32'h200, 32'h0011_02B3);
    bus.if_pc       = 32'h204;
    bus.if_instr    = 32'h0050_0093;
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd2;
    #1;
    chk("stall_rs1", 32'(bus.is_stall), 32'd1);
    chk("stall_valid", 32'(bus.id_valid), 32'd0);
    chk_ctrl("stall_ctrl", '0);
    tick();
    bus.ex_rd = 5'd1;
    #1;
    chk("stall_rs2", 32'(bus.is_stall), 32'd1);
    bus.ex_rd = 5'd0;
    #1;
    chk("nostall_x0", 32'(bus.is_stall), 32'd0);
    bus.ex_mem_read = 1'b0;
    #1;
    chk("unstall", 32'(bus.is_stall), 32'd0);
    chk("held_pc", bus.id_pc, 32'h200);
    chk("held_rd", 32'(bus.rd), 32'd5);
    chk_ctrl("held_ctrl", mk(AluAdd, 9'b0_0_0_1_0_0_0_0_0));

    // beq x0, x0, +8 decoded, then flushed
    fetch(32'h300, 32'h0000_0463);
    chk("beq_imm", bus.imm, 32'h8);
    chk_ctrl("beq_ctrl", mk(AluSub, 9'b0_0_0_0_1_0_0_0_0));
    bus.is_flush = 1'b1;
    fetch(32'h304, 32'h0000_0463);
    chk("flush_valid", 32'(bus.id_valid), 32'd0);
    chk("flush_rd", 32'(bus.rd), 32'd0);
    chk("flush_imm", bus.imm, 32'd0);
    chk_ctrl("flush_ctrl", '0);

    // flush and stall in the same cycle
    bus.is_flush = 1'b0;
    fetch(32'h400, 32'h0011_02B3);
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd2;
    bus.is_flush    = 1'b1;
    #1;
    chk("fs_stall_pre", 32'(bus.is_stall), 32'd1);
    tick();
    chk("fs_stall_post", 32'(bus.is_stall), 32'd0);
    chk("fs_valid", 32'(bus.id_valid), 32'd0);
    chk("fs_rd", 32'(bus.rd), 32'd0);
    bus.is_flush    = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rd       = 5'd0;

    // sub x3, x1, x2
    fetch(32'h500, 32'h4020_81B3);
    chk("sub_f7b5", 32'(bus.funct7_b5), 32'd1);
    chk_ctrl("sub_ctrl", mk(AluSub, 9'b0_0_0_1_0_0_0_0_0));

    // sw x2, -4(x1)
    fetch(32'h504, 32'hFE20_AE23);
    chk("sw_imm", bus.imm, 32'hFFFF_FFFC);
    chk("sw_f3", 32'(bus.funct3), 32'd2);
    chk_ctrl("sw_ctrl", mk(AluAdd, 9'b1_0_1_0_0_0_0_0_0));

    // jal x1, +2048
    fetch(32'h508, 32'h0010_00EF);
    chk("jal_imm", bus.imm, 32'h0000_0800);
    chk_ctrl("jal_ctrl", mk(AluAdd, 9'b0_0_0_1_0_1_0_0_0));

    // lui x5, 0x12345
    fetch(32'h50C, 32'h1234_52B7);
    chk("lui_imm", bus.imm, 32'h1234_5000);
    chk_ctrl("lui_ctrl", mk(AluAdd, 9'b1_0_0_1_0_0_0_1_0));

    // opcode 0x7F
    fetch(32'h510, 32'h0000_007F);
    chk("ill_flag", 32'(bus.is_illegal), 32'd1);
    chk("ill_valid", 32'(bus.id_valid), 32'd1);
    chk_ctrl("ill_ctrl", '0);

    // reset in the middle of a hazard cycle
    fetch(32'h600, 32'h0001_8233);
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd3;
    #1;
    chk("pre_rst_stall", 32'(bus.is_stall), 32'd1);
    bus.ex_mem_read = 1'b0;
    #1;
    chk("pre_rst_rs1", bus.rs1_data, 32'hDEAD_BEEF);
    bus.ex_mem_read = 1'b1;
    reset = 1'b0;
    #1;
    chk("mrst_valid", 32'(bus.id_valid), 32'd0);
    chk("mrst_pc", bus.id_pc, 32'd0);
    chk("mrst_imm", bus.imm, 32'd0);
    chk("mrst_stall", 32'(bus.is_stall), 32'd0);
    chk("mrst_rs1", bus.rs1_data, 32'd0);
    chk_ctrl("mrst_ctrl", '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
